// File: rtl/clz_pipelined_counter.sv
// clz_pipelined_counter: two-stage leading/trailing zero counter with valid/ready flow control
module clz_pipelined_counter #(
   parameter int DATA_WIDTH = 32,
   localparam int CW = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  mode_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [CW-1:0]         count_o,
   output logic                  all_zero_o,
   output logic                  valid_o,
   input  logic                  ready_i
);
   localparam int NIBBLES = DATA_WIDTH / 4;
   logic [DATA_WIDTH-1:0]  norm;
   logic [NIBBLES-1:0]     zf_d, s1_zf;
   logic [2*NIBBLES-1:0]   lc_d, s1_lc;
   logic                   s1_valid, s1_adv, s2_load, accept;
   logic [CW-1:0]          cnt_d;
   logic                   az_d;
   assign s2_load = !valid_o | ready_i;
   assign s1_adv  = s1_valid & s2_load;
   assign ready_o = !s1_valid | s1_adv;
   assign accept  = valid_i & ready_o;
   // bit-reverse in trailing mode so both modes become a leading-zero count
   always_comb begin
      norm = data_i;
      for (int b = 0; b < DATA_WIDTH; b++)
         norm[b] = mode_i ? data_i[DATA_WIDTH-1-b] : data_i[b];
   end
   for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
      logic [3:0] nib;
      assign nib             = norm[DATA_WIDTH-1-4*i -: 4];
      assign zf_d[i]         = nib == 4'b0;
      assign lc_d[2*i +: 2]  = nib[3] ? 2'd0 : nib[2] ? 2'd1 : nib[1] ? 2'd2 : 2'd3;
   end
   // stage 1: per-nibble zero flags and local counts, captured on accept
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid <= 1'b0;
         s1_zf    <= '0;
         s1_lc    <= '0;
      end else begin
         if (ready_o) s1_valid <= valid_i;
         if (accept) begin
            s1_zf <= zf_d;
            s1_lc <= lc_d;
         end
      end
   end
   // priority encoder: the lowest index (closest to MSB) non-zero nibble wins
   always_comb begin
      cnt_d = CW'(DATA_WIDTH);
      az_d  = 1'b1;
      for (int i = NIBBLES - 1; i >= 0; i--)
         if (!s1_zf[i]) begin
            cnt_d = CW'(4 * i) + CW'(s1_lc[2*i +: 2]);
            az_d  = 1'b0;
         end
   end
   // stage 2: result register, held while downstream stalls
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_o    <= 1'b0;
         count_o    <= '0;
         all_zero_o <= 1'b0;
      end else begin
         if (s2_load) valid_o <= s1_valid;
         if (s1_adv) begin
            count_o    <= cnt_d;
            all_zero_o <= az_d;
         end
      end
   end
endmodule

// File: tb/tb_clz_pipelined_counter.sv
// tb_clz_pipelined_counter: randomized and directed checks of the zero counter at widths 8, 32 and 128
module tb_clz_pipelined_counter;
   logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, mode = 1'b0, rdy = 1'b0;
   logic [7:0]   d8 = '0;
   logic [31:0]  d32 = '0;
   logic [127:0] d128 = '0;
   logic ro8, ro32, ro128, vo8, vo32, vo128, az8, az32, az128;
   logic [3:0] c8;
   logic [5:0] c32;
   logic [7:0] c128;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   clz_pipelined_counter #(.DATA_WIDTH(8)) u8 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(d8), .mode_i(mode), .valid_i(valid),
      .ready_o(ro8), .count_o(c8), .all_zero_o(az8), .valid_o(vo8), .ready_i(rdy));
   clz_pipelined_counter #(.DATA_WIDTH(32)) u32 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(d32), .mode_i(mode), .valid_i(valid),
      .ready_o(ro32), .count_o(c32), .all_zero_o(az32), .valid_o(vo32), .ready_i(rdy));
   clz_pipelined_counter #(.DATA_WIDTH(128)) u128 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(d128), .mode_i(mode), .valid_i(valid),
      .ready_o(ro128), .count_o(c128), .all_zero_o(az128), .valid_o(vo128), .ready_i(rdy));

   // reference: walk bits from the counting end until the first one
   function automatic int ref_cnt(input logic [127:0] d, input logic m, input int w);
      for (int n = 0; n < w; n++)
         if (d[m ? n : w - 1 - n]) return n;
      return w;
   endfunction

   function automatic logic [127:0] rnd(input int w);
      logic [127:0] x, mask;
      int s, sel;
      mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
      x = {$urandom, $urandom, $urandom, $urandom} & mask;
      s = $urandom_range(0, w - 1);
      sel = $urandom_range(0, 9);
      if (sel < 4) x = x >> s;
      else if (sel < 8) x = (x << s) & mask;
      else if (sel == 8) x = 128'd1 << s;
      else x = '0;
      return x;
   endfunction

   task automatic drive(input logic v, input logic m, input logic r,
                        input logic [127:0] a, input logic [31:0] b, input logic [7:0] c);
      @(negedge clk);
      valid = v; mode = m; rdy = r; d128 = a; d32 = b; d8 = c;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (vo32 !== 1'b0 || c32 !== 6'd0 || az32 !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs valid=%b count=%0d all_zero=%b required 0/0/0", vo32, c32, az32);
      end
      rst_n = 1'b1;
      idle(1);
      checks++;
      if (ro32 !== 1'b1 || vo32 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release ready=%b valid=%b required ready=1 valid=0", ro32, vo32);
      end
   endtask

   task automatic run_table(input string name, input logic [31:0] ops [], input logic md [],
                            input int exp [], input logic az []);
      int n;
      n = ops.size();
      for (int j = 0; j < n + 2; j++) begin
         drive(j < n, j < n ? md[j] : 1'b0, 1'b1, '0, j < n ? ops[j] : 32'd0, '0);
         checks++;
         if (j < 2) begin
            if (vo32 !== 1'b0) begin
               errors++;
               $display("FAIL %s_latency cycle %0d valid=%b required 0", name, j, vo32);
            end
         end else if (vo32 !== 1'b1 || c32 !== 6'(exp[j-2]) || az32 !== az[j-2]) begin
            errors++;
            $display("FAIL %s_result %0d valid=%b count=%0d all_zero=%b required 1/%0d/%b",
                     name, j - 2, vo32, c32, az32, exp[j-2], az[j-2]);
         end
         if (j < n && ro32 !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_ready cycle %0d ready=%b required 1", name, j, ro32);
         end
      end
      idle(2);
   endtask

   task automatic test_basic;
      run_table("basic", '{32'h0001_0000, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF},
                '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1}, '{15, 16, 0, 31, 0}, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
   endtask

   task automatic test_all_zero;
      run_table("all_zero", '{32'h0, 32'h0, 32'h1}, '{1'b0, 1'b1, 1'b0}, '{32, 32, 31}, '{1'b1, 1'b1, 1'b0});
   endtask

   task automatic test_back_to_back_backpressure;
      logic [31:0] ops [4] = '{32'h1, 32'h10, 32'h100, 32'h1000};
      int exp [4] = '{31, 27, 23, 19};
      int idx = 0;
      for (int k = 0; k < 4; k++) begin
         drive(idx < 4, 1'b0, 1'b0, '0, idx < 4 ? ops[idx] : 32'd0, '0);
         checks++;
         if (ro32 !== (k < 2)) begin
            errors++;
            $display("FAIL bp_ready stall cycle %0d ready=%b required %b", k, ro32, k < 2);
         end
         if (k >= 2) begin
            checks++;
            if (vo32 !== 1'b1 || c32 !== 6'd31) begin
               errors++;
               $display("FAIL bp_hold cycle %0d valid=%b count=%0d required 1/31", k, vo32, c32);
            end
         end
         if (valid && ro32) idx++;
      end
      for (int k = 0; k < 5; k++) begin
         drive(idx < 4, 1'b0, 1'b1, '0, idx < 4 ? ops[idx] : 32'd0, '0);
         checks++;
         if (k < 4 && (vo32 !== 1'b1 || c32 !== 6'(exp[k]))) begin
            errors++;
            $display("FAIL bp_drain %0d valid=%b count=%0d required 1/%0d", k, vo32, c32, exp[k]);
         end else if (k == 4 && vo32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_extra valid=%b required 0", vo32);
         end
         if (valid && ro32) idx++;
      end
      checks++;
      if (idx != 4) begin
         errors++;
         $display("FAIL bp_accepts accepted=%0d required 4", idx);
      end
      idle(2);
   endtask

   task automatic test_reset_mid;
      drive(1'b1, 1'b0, 1'b0, '0, 32'h1, '0);
      drive(1'b1, 1'b0, 1'b0, '0, 32'h10, '0);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      checks++;
      if (vo32 !== 1'b1 || ro32 !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_full valid=%b ready=%b required 1/0", vo32, ro32);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (vo32 !== 1'b0 || c32 !== 6'd0 || az32 !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_clear valid=%b count=%0d all_zero=%b required 0/0/0", vo32, c32, az32);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
         checks++;
         if (ro32 !== 1'b1 || vo32 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale cycle %0d ready=%b valid=%b required 1/0", k, ro32, vo32);
         end
      end
   endtask

   task automatic test_random_sweep;
      int q8[$], q32[$], q128[$];
      int e8, e32, e128;
      logic [127:0] a;
      logic [31:0] b;
      logic [7:0] c;
      logic m, v, r;
      for (int t = 0; t < 640; t++) begin
         if (t < 4) begin
            m = t[0];
            v = 1'b1;
            r = 1'b1;
            a = (t < 2) ? 128'd0 : (128'd1 << 127);
            b = (t < 2) ? 32'd0 : 32'h8000_0000;
            c = (t < 2) ? 8'd0 : 8'h80;
         end else begin
            m = 1'($urandom);
            v = (t < 600) && ($urandom_range(0, 3) != 0);
            r = (t >= 600) || ($urandom_range(0, 3) != 0);
            a = rnd(128);
            b = 32'(rnd(32));
            c = 8'(rnd(8));
         end
         drive(v, m, r, a, b, c);
         checks++;
         if (vo8 !== vo32 || vo128 !== vo32 || ro8 !== ro32 || ro128 !== ro32) begin
            errors++;
            $display("FAIL rand_lockstep t=%0d valid=%b%b%b ready=%b%b%b required equal", t,
                     vo8, vo32, vo128, ro8, ro32, ro128);
         end
         if (vo32 && rdy) begin
            checks++;
            if (q32.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious t=%0d count=%0d required no result", t, c32);
            end else begin
               e8 = q8.pop_front();
               e32 = q32.pop_front();
               e128 = q128.pop_front();
               if (c8 !== 4'(e8) || az8 !== (e8 == 8)) begin
                  errors++;
                  $display("FAIL rand_w8 t=%0d count=%0d all_zero=%b required %0d/%b", t, c8, az8, e8, e8 == 8);
               end
               checks++;
               if (c32 !== 6'(e32) || az32 !== (e32 == 32)) begin
                  errors++;
                  $display("FAIL rand_w32 t=%0d count=%0d all_zero=%b required %0d/%b", t, c32, az32, e32, e32 == 32);
               end
               checks++;
               if (c128 !== 8'(e128) || az128 !== (e128 == 128)) begin
                  errors++;
                  $display("FAIL rand_w128 t=%0d count=%0d all_zero=%b required %0d/%b", t, c128, az128, e128, e128 == 128);
               end
            end
         end
         if (valid && ro32) begin
            q8.push_back(ref_cnt({120'd0, c}, m, 8));
            q32.push_back(ref_cnt({96'd0, b}, m, 32));
            q128.push_back(ref_cnt(a, m, 128));
         end
      end
      checks++;
      if (q32.size() != 0) begin
         errors++;
         $display("FAIL rand_drain outstanding=%0d required 0", q32.size());
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_all_zero;
      test_back_to_back_backpressure;
      test_reset_mid;
      test_random_sweep;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
